// File: rtl/oled_field_fmt_pkg.sv
// Shared constants for the OLED field formatter: ASCII codes, FSM state encoding
// and constant width helpers.
package oled_fmt_pkg;

   localparam logic [7:0] ASCII_SPACE  = 8'h20;
   localparam logic [7:0] ASCII_ZERO   = 8'h30;
   localparam logic [7:0] ASCII_DOLLAR = 8'h24;
   localparam logic [7:0] ASCII_DOT    = 8'h2E;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_FORMAT = 2'd2;
   localparam logic [1:0] ST_WRITE  = 2'd3;

   function automatic int clog2(input int n);
      int r;
      r = 32'sd0;
      while ((32'sd1 << r) < n) begin
         r = r + 32'sd1;
      end
      return r;
   endfunction

   // Field index width never collapses to zero bits, even for a single field.
   function automatic int sel_width(input int n);
      return (clog2(n) < 32'sd1) ? 32'sd1 : clog2(n);
   endfunction

endpackage

// File: rtl/oled_field_fmt_if.sv
// Request/response bundle between the vending FSM (master) and the field formatter (slave).
interface oled_field_fmt_if
   import oled_fmt_pkg::*;
#(
   parameter int N_FIELDS = 4,
   parameter int VAL_W    = 8,
   parameter int CHARS    = 12,
   parameter int SEL_W    = sel_width(N_FIELDS)
);
   logic                      ld;
   logic [SEL_W-1:0]          ld_sel;
   logic [VAL_W-1:0]          ld_val;
   logic                      ld_disp;
   logic [SEL_W-1:0]          disp_sel;
   logic                      busy;
   logic                      done;
   logic                      err;
   logic [N_FIELDS*CHARS*8-1:0] fields;
   logic [CHARS*8-1:0]        disp;

   modport master (
      output ld, ld_sel, ld_val, ld_disp, disp_sel,
      input  busy, done, err, fields, disp
   );

   modport slave (
      input  ld, ld_sel, ld_val, ld_disp, disp_sel,
      output busy, done, err, fields, disp
   );
endinterface

// File: rtl/oled_field_fmt_bin2bcd.sv
// Sequential double-dabble engine: one value bit per cycle, MSB first; bcd_done
// marks the cycle whose edge performs the final shift.
module bin2bcd_iter
   import oled_fmt_pkg::*;
#(
   parameter int VAL_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  clr_reg,
   input  logic                  start,
   input  logic [VAL_W-1:0]      val,
   output logic [DIGITS*4-1:0]   bcd_out,
   output logic                  bcd_done
);
   localparam int CNT_W = clog2(VAL_W + 1);

   logic [VAL_W-1:0]    val_r;
   logic [DIGITS*4-1:0] bcd_r;
   logic [DIGITS*4-1:0] adj_s;
   logic [CNT_W-1:0]    cnt_r;

   function automatic logic [DIGITS*4-1:0] dabble_adj(input logic [DIGITS*4-1:0] b);
      logic [DIGITS*4-1:0] r;
      r = b;
      for (int d = 0; d < DIGITS; d++) begin
         if (b[d*4 +: 4] >= 4'd5) begin
            r[d*4 +: 4] = b[d*4 +: 4] + 4'd3;
         end else begin
            r[d*4 +: 4] = b[d*4 +: 4];
         end
      end
      return r;
   endfunction

   assign adj_s    = dabble_adj(bcd_r);
   assign bcd_out  = bcd_r;
   assign bcd_done = (cnt_r == CNT_W'(1));

   // Load on start, then adjust-and-shift until the bit counter runs out.
   always_ff @(posedge clk) begin
      if (clr_reg) begin
         val_r <= '0;
         bcd_r <= '0;
         cnt_r <= '0;
      end else if (start) begin
         val_r <= val;
         bcd_r <= '0;
         cnt_r <= CNT_W'(VAL_W);
      end else if (cnt_r != '0) begin
         {bcd_r, val_r} <= {adj_s, val_r} << 1;
         cnt_r          <= cnt_r - CNT_W'(1);
      end else begin
         val_r <= val_r;
         bcd_r <= bcd_r;
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/oled_field_fmt.sv
// OLED text-field bank: converts binary values to right-justified ASCII fields and
// snapshots one field into a display register. Define OLED_CURRENCY_FMT_EN for "$D.CC" output.
module oled_field_fmt
   import oled_fmt_pkg::*;
#(
   parameter int N_FIELDS = 4,
   parameter int VAL_W    = 8,
   parameter int DIGITS   = 3,
   parameter int CHARS    = 12,
   parameter int SEL_W    = sel_width(N_FIELDS)
) (
   input logic             clk,
   input logic             clr_reg,
   oled_field_fmt_if.slave bus
);
   localparam int FW = CHARS * 8;

   logic [1:0]             state_r;
   logic [1:0]             state_nxt_s;
   logic [SEL_W-1:0]       sel_r;
   logic [FW-1:0]          stage_r;
   logic [FW-1:0]          str_s;
   logic [FW-1:0]          disp_r;
   logic [FW-1:0]          fields_r [N_FIELDS];
   logic [N_FIELDS*FW-1:0] fields_flat_s;
   logic                   busy_r;
   logic                   done_r;
   logic                   err_r;
   logic                   start_s;
   logic                   fmt_en_s;
   logic                   wr_en_s;
   logic                   ld_rej_s;
   logic                   ld_sel_ok_s;
   logic                   disp_sel_ok_s;
   logic [DIGITS*4-1:0]    bcd_s;
   logic                   bcd_done_s;
   int                     lead_v;

   assign ld_sel_ok_s   = (32'(bus.ld_sel) < 32'(N_FIELDS));
   assign disp_sel_ok_s = (32'(bus.disp_sel) < 32'(N_FIELDS));

   bin2bcd_iter #(.VAL_W(VAL_W), .DIGITS(DIGITS)) u_bcd (
      .clk      (clk),
      .clr_reg  (clr_reg),
      .start    (start_s),
      .val      (bus.ld_val),
      .bcd_out  (bcd_s),
      .bcd_done (bcd_done_s)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (clr_reg) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE:   state_nxt_s = start_s ? ST_SHIFT : ST_IDLE;
         ST_SHIFT:  state_nxt_s = bcd_done_s ? ST_FORMAT : ST_SHIFT;
         ST_FORMAT: state_nxt_s = ST_WRITE;
         ST_WRITE:  state_nxt_s = ST_IDLE;
         default:   state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM output decode; any ld outside IDLE or with a bad index is rejected.
   always_comb begin
      start_s  = 1'b0;
      fmt_en_s = 1'b0;
      wr_en_s  = 1'b0;
      ld_rej_s = bus.ld && !ld_sel_ok_s;
      case (state_r)
         ST_IDLE:   start_s  = bus.ld && ld_sel_ok_s;
         ST_SHIFT:  ld_rej_s = bus.ld;
         ST_FORMAT: begin
            fmt_en_s = 1'b1;
            ld_rej_s = bus.ld;
         end
         ST_WRITE:  begin
            wr_en_s  = 1'b1;
            ld_rej_s = bus.ld;
         end
         default:   ld_rej_s = bus.ld;
      endcase
   end

   // ASCII rendering of the finished BCD digits; lead_v is the highest printed digit.
   always_comb begin
      str_s  = {CHARS{ASCII_SPACE}};
      lead_v = 32'sd0;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd_s[d*4 +: 4] != 4'd0) begin
            lead_v = d;
         end else begin
            lead_v = lead_v;
         end
      end
`ifdef OLED_CURRENCY_FMT_EN
      if (lead_v < 32'sd2) begin
         lead_v = 32'sd2;
      end else begin
         lead_v = lead_v;
      end
      str_s[7:0]   = ASCII_ZERO + {4'd0, bcd_s[3:0]};
      str_s[15:8]  = ASCII_ZERO + {4'd0, bcd_s[7:4]};
      str_s[23:16] = ASCII_DOT;
      for (int d = 2; d < DIGITS; d++) begin
         if (d <= lead_v) begin
            str_s[(d+1)*8 +: 8] = ASCII_ZERO + {4'd0, bcd_s[d*4 +: 4]};
         end else begin
            str_s[(d+1)*8 +: 8] = ASCII_SPACE;
         end
      end
      str_s[(lead_v+2)*8 +: 8] = ASCII_DOLLAR;
`else
      for (int d = 0; d < DIGITS; d++) begin
         if (d <= lead_v) begin
            str_s[d*8 +: 8] = ASCII_ZERO + {4'd0, bcd_s[d*4 +: 4]};
         end else begin
            str_s[d*8 +: 8] = ASCII_SPACE;
         end
      end
`endif
   end

   // Request latch, staging register and status pulses.
   always_ff @(posedge clk) begin
      if (clr_reg) begin
         sel_r   <= '0;
         stage_r <= {CHARS{ASCII_SPACE}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         sel_r   <= start_s ? bus.ld_sel : sel_r;
         stage_r <= fmt_en_s ? str_s : stage_r;
         busy_r  <= (state_nxt_s != ST_IDLE);
         done_r  <= wr_en_s;
         err_r   <= ld_rej_s || (bus.ld_disp && !disp_sel_ok_s);
      end
   end

   // Field bank; the display copy below reads the pre-write contents on a shared edge.
   always_ff @(posedge clk) begin
      if (clr_reg) begin
         for (int k = 0; k < N_FIELDS; k++) begin
            fields_r[k] <= {CHARS{ASCII_SPACE}};
         end
      end else if (wr_en_s) begin
         fields_r[sel_r] <= stage_r;
      end else begin
         fields_r <= fields_r;
      end
   end

   // Display snapshot register.
   always_ff @(posedge clk) begin
      if (clr_reg) begin
         disp_r <= {CHARS{ASCII_SPACE}};
      end else if (bus.ld_disp && disp_sel_ok_s) begin
         disp_r <= fields_r[bus.disp_sel];
      end else begin
         disp_r <= disp_r;
      end
   end

   always_comb begin
      fields_flat_s = '0;
      for (int k = 0; k < N_FIELDS; k++) begin
         fields_flat_s[k*FW +: FW] = fields_r[k];
      end
   end

   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
   assign bus.err    = err_r;
   assign bus.fields = fields_flat_s;
   assign bus.disp   = disp_r;

endmodule

// File: tb/tb_oled_field_fmt.sv
// Scoreboard bench for oled_field_fmt (3-field build so out-of-range indices exist);
// expected strings come from $sformatf of the value, in plain or currency form.
module tb_oled_field_fmt;
   import oled_fmt_pkg::*;

   localparam int N_FIELDS = 3;
   localparam int VAL_W    = 8;
   localparam int DIGITS   = 3;
   localparam int CHARS    = 12;
   localparam int SEL_W    = sel_width(N_FIELDS);
   localparam int FW       = CHARS * 8;

   typedef logic [FW-1:0]          field_t;
   typedef logic [N_FIELDS*FW-1:0] bank_t;
   typedef struct { int at; bank_t bank; }               done_exp_t;
   typedef struct { int at; field_t val; }               disp_exp_t;
   typedef struct { int at; bank_t bank; field_t disp; } snap_exp_t;

   logic clk = 1'b0;
   logic clr_reg;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;

   oled_field_fmt_if #(.N_FIELDS(N_FIELDS), .VAL_W(VAL_W), .CHARS(CHARS), .SEL_W(SEL_W)) bus ();

   oled_field_fmt #(.N_FIELDS(N_FIELDS), .VAL_W(VAL_W), .DIGITS(DIGITS), .CHARS(CHARS),
                    .SEL_W(SEL_W)) dut (
      .clk     (clk),
      .clr_reg (clr_reg),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model state and scoreboard queues.
   field_t    mfield [N_FIELDS];
   field_t    mdisp;
   int        busy_lo = 1;
   int        busy_hi = 0;
   bit        pend_valid = 1'b0;
   int        pend_edge;
   int        pend_sel;
   field_t    pend_str;
   done_exp_t done_q[$];
   disp_exp_t disp_q[$];
   snap_exp_t snap_q[$];
   int        err_q[$];

   function automatic field_t spaces();
      field_t r;
      for (int i = 0; i < CHARS; i++) r[i*8 +: 8] = 8'h20;
      return r;
   endfunction

   function automatic field_t fmt_ref(input int v);
      string  s;
      field_t r;
`ifdef OLED_CURRENCY_FMT_EN
      s = $sformatf("$%0d.%02d", v / 100, v % 100);
`else
      s = $sformatf("%0d", v);
`endif
      r = spaces();
      for (int i = 0; i < s.len(); i++) r[(s.len()-1-i)*8 +: 8] = s[i];
      return r;
   endfunction

   function automatic bank_t model_bank();
      bank_t b;
      for (int k = 0; k < N_FIELDS; k++) b[k*FW +: FW] = mfield[k];
      return b;
   endfunction

   task automatic chk(input string name, input bank_t act, input bank_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // Apply one cycle of inputs and record what the model predicts for the next edge.
   task automatic drive(input bit clr, input bit ld, input int sel, input int val,
                        input bit dld, input int dsel);
      int        c;
      int        e;
      bit        err_e;
      done_exp_t de;
      disp_exp_t dd;
      snap_exp_t sn;
      c = cyc;
      e = c + 1;
      clr_reg      = clr;
      bus.ld       = ld;
      bus.ld_sel   = SEL_W'(sel);
      bus.ld_val   = VAL_W'(val);
      bus.ld_disp  = dld;
      bus.disp_sel = SEL_W'(dsel);
      if (clr) begin
         for (int k = 0; k < N_FIELDS; k++) mfield[k] = spaces();
         mdisp      = spaces();
         pend_valid = 1'b0;
         if (busy_hi > c) busy_hi = c;
         while (done_q.size() > 0 && done_q[$].at > c) void'(done_q.pop_back());
         sn.at = e; sn.bank = model_bank(); sn.disp = mdisp;
         snap_q.push_back(sn);
      end else begin
         if (pend_valid && pend_edge <= c) begin
            mfield[pend_sel] = pend_str;
            pend_valid = 1'b0;
         end
         err_e = 1'b0;
         if (ld) begin
            if (sel >= N_FIELDS || (c >= busy_lo && c <= busy_hi)) begin
               err_e = 1'b1;
            end else begin
               busy_lo    = e;
               busy_hi    = e + VAL_W + 1;
               pend_valid = 1'b1;
               pend_edge  = e + VAL_W + 2;
               pend_sel   = sel;
               pend_str   = fmt_ref(val);
               de.at      = pend_edge;
               de.bank    = model_bank();
               de.bank[sel*FW +: FW] = pend_str;
               done_q.push_back(de);
            end
         end
         if (dld) begin
            if (dsel >= N_FIELDS) err_e = 1'b1;
            else mdisp = mfield[dsel];
            dd.at = e; dd.val = mdisp;
            disp_q.push_back(dd);
         end
         if (err_e) err_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 1'b0, 0);
   endtask

   // Monitor: compares DUT outputs against the queued expectations on each falling edge.
   initial begin : monitor
      bit exp_b;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            exp_b = (cyc >= busy_lo && cyc <= busy_hi);
            chk("busy", bank_t'(bus.busy), bank_t'(exp_b));
            if (done_q.size() > 0 && done_q[0].at == cyc) begin
               chk("done", bank_t'(bus.done), bank_t'(1'b1));
               chk("fields_at_done", bus.fields, done_q[0].bank);
               void'(done_q.pop_front());
            end else if (bus.done !== 1'b0) begin
               chk("done_unexpected", bank_t'(bus.done), bank_t'(1'b0));
            end
            if (err_q.size() > 0 && err_q[0] == cyc) begin
               chk("err", bank_t'(bus.err), bank_t'(1'b1));
               void'(err_q.pop_front());
            end else if (bus.err !== 1'b0) begin
               chk("err_unexpected", bank_t'(bus.err), bank_t'(1'b0));
            end
            if (disp_q.size() > 0 && disp_q[0].at == cyc) begin
               chk("disp", bank_t'(bus.disp), bank_t'(disp_q[0].val));
               void'(disp_q.pop_front());
            end
            if (snap_q.size() > 0 && snap_q[0].at == cyc) begin
               chk("reset_fields", bus.fields, snap_q[0].bank);
               chk("reset_disp", bank_t'(bus.disp), bank_t'(snap_q[0].disp));
               void'(snap_q.pop_front());
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog cyc=%0d bench did not complete", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      clr_reg = 1'b1;
      bus.ld = 1'b0; bus.ld_sel = '0; bus.ld_val = '0; bus.ld_disp = 1'b0; bus.disp_sel = '0;
      @(posedge clk);
      #1;
      // Reset held for two cycles.
      drive(1'b1, 1'b0, 0, 0, 1'b0, 0);
      mon_en = 1'b1;
      drive(1'b1, 1'b0, 0, 0, 1'b0, 0);
      // 250 into field0, a rejected ld mid-flight, then display snapshot.
      drive(1'b0, 1'b1, 0, 250, 1'b0, 0);
      idle(2);
      drive(1'b0, 1'b1, 1, 100, 1'b0, 0);
      idle(8);
      drive(1'b0, 1'b0, 0, 0, 1'b1, 0);
      // 0 then 5 into field2; second ld lands exactly in the done cycle.
      drive(1'b0, 1'b1, 2, 0, 1'b0, 0);
      idle(VAL_W + 1);
      drive(1'b0, 1'b0, 0, 0, 1'b1, 2);
      drive(1'b0, 1'b1, 2, 5, 1'b0, 0);
      idle(VAL_W);
      drive(1'b0, 1'b0, 0, 0, 1'b1, 2);
      drive(1'b0, 1'b0, 0, 0, 1'b1, 2);
      // Out-of-range field and display indices.
      drive(1'b0, 1'b1, 3, 77, 1'b0, 0);
      drive(1'b0, 1'b0, 0, 0, 1'b1, 3);
      idle(2);
      // 150 into field2, reset on the 4th SHIFT cycle, then a clean retry.
      drive(1'b0, 1'b1, 2, 150, 1'b0, 0);
      idle(3);
      drive(1'b1, 1'b0, 0, 0, 1'b0, 0);
      idle(VAL_W + 4);
      drive(1'b0, 1'b1, 2, 150, 1'b0, 0);
      idle(VAL_W + 2);
      drive(1'b0, 1'b0, 0, 0, 1'b1, 2);
      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 30),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
               ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
      end
      idle(VAL_W + 6);
      chk("done_queue_drained", bank_t'(done_q.size()), bank_t'(0));
      chk("err_queue_drained", bank_t'(err_q.size()), bank_t'(0));
      chk("disp_queue_drained", bank_t'(disp_q.size()), bank_t'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
